// File: rtl/mips_pkg.sv
// Shared types and address-field width helpers for the MIPS instruction cache.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int line_words);
        return WORD_W - 2 - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/mips_icache_tag_array.sv
// Tag and valid storage for the direct-mapped icache, with flush-clear and hit compare.
module icache_tag_array
    import mips_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       inv_en,
    input  logic [idx_w(LINES)-1:0]    inv_idx,
    input  logic                       wr_en,
    input  logic [idx_w(LINES)-1:0]    wr_idx,
    input  logic [TAG_W-1:0]           wr_tag,
    input  logic [idx_w(LINES)-1:0]    rd_idx,
    input  logic [TAG_W-1:0]           rd_tag,
    output logic                       hit
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (inv_en) valid[inv_idx] <= 1'b0;
            if (wr_en)  valid[wr_idx]  <= 1'b1;
        end
    end

    // Tags are not reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (wr_en) tags[wr_idx] <= wr_tag;
    end

    assign hit = valid[rd_idx] && (tags[rd_idx] == rd_tag);

endmodule

// File: rtl/mips_icache.sv
// Direct-mapped read-only instruction cache with combinational hit path and line fill.
// Optional hit/miss counters are enabled with ICACHE_STATS_EN.
module mips_icache
    import mips_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OW = off_w(LINE_WORDS);
    localparam int IW = idx_w(LINES);
    localparam int TW = tag_w(LINES, LINE_WORDS);

    logic [OW-1:0] a_off;
    logic [IW-1:0] a_idx;
    logic [TW-1:0] a_tag;
    logic          unused_addr_bits;

    assign a_off            = cpu_addr[OW+1:2];
    assign a_idx            = cpu_addr[OW+IW+1:OW+2];
    assign a_tag            = cpu_addr[31:OW+IW+2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    icache_state_t state;
    logic [TW-1:0] fill_tag;
    logic [IW-1:0] fill_idx;
    logic [OW-1:0] cnt;

    logic [WORD_W-1:0] data_mem [LINES][LINE_WORDS];

    logic tag_hit, hit, miss_start, accept, last_word;

    assign hit        = cpu_req && tag_hit;
    assign miss_start = (state == IDLE) && cpu_req && !tag_hit && !flush;
    assign accept     = (state == FILL) && mem_valid && !flush;
    assign last_word  = (cnt == OW'(LINE_WORDS - 1));

    icache_tag_array #(
        .LINES (LINES),
        .TAG_W (TW)
    ) u_tags (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .inv_en  (miss_start),
        .inv_idx (a_idx),
        .wr_en   (accept && last_word),
        .wr_idx  (fill_idx),
        .wr_tag  (fill_tag),
        .rd_idx  (a_idx),
        .rd_tag  (a_tag),
        .hit     (tag_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            fill_tag <= '0;
            fill_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        state    <= FILL;
                        fill_tag <= a_tag;
                        fill_idx <= a_idx;
                        cnt      <= '0;
                    end
                end
                FILL: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (mem_valid) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) data_mem[fill_idx][cnt] <= mem_rdata;
    end

    // A flush cycle stalls even on a tag match, since the line is about to vanish.
    assign cpu_ready = !cpu_req || ((state == IDLE) && tag_hit && !flush);
    assign cpu_rdata = data_mem[a_idx][a_off];
    assign mem_req   = (state == FILL);
    assign mem_addr  = mem_req ? {fill_tag, fill_idx, cnt, 2'b00} : 32'h0;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if ((state == IDLE) && hit) hit_count <= hit_count + 32'd1;
            if (miss_start)             miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mips_icache.md
# mips_icache

Direct-mapped, read-only instruction cache between the pipelined MIPS fetch stage and a multi-cycle instruction memory. The fetch stage presents PC. A hit returns the instruction in the same cycle, matching the asynchronous-read instruction memory the core expects. A miss deasserts `cpu_ready`, which the core ORs into its stall, while the cache fills a whole line from memory one word per handshake.

## Interface
Parameters:
- `LINES`, default 16: number of lines; power of two, at least 2.
- `LINE_WORDS`, default 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `cpu_req`, input, 1: fetch request valid; the core holds it high in normal operation.
- `cpu_addr`, input, 32: byte address (PC); bits [1:0] are ignored.
- `cpu_rdata`, output, 32: instruction; valid only when `cpu_ready` is high.
- `cpu_ready`, output, 1: hit this cycle; when low, the core must stall and hold `cpu_addr`.
- `flush`, input, 1: invalidate all lines (single-cycle pulse).
- `mem_req`, output, 1: word read request to backing memory.
- `mem_addr`, output, 32: word-aligned fill address.
- `mem_rdata`, input, 32: fill data.
- `mem_valid`, input, 1: `mem_rdata` is valid for the current `mem_req`.

## Operation
- Address split, with O = log2(LINE_WORDS) and I = log2(LINES):
  - word offset: [O+1:2]
  - index: [O+I+1:O+2]
  - tag: [31:O+I+2]
  - Defaults: offset [3:2], index [7:4], tag [31:8] (24 bits).
- Storage:
  - data array of LINES×LINE_WORDS×32 bits;
  - tag array of LINES entries;
  - valid bit per line.
- Hit condition: `cpu_req` && valid[index] && tag[index] == addr tag. On a hit, `cpu_ready` = 1 and `cpu_rdata` = data[index][offset], purely combinational.
- `cpu_req` low: `cpu_ready` = 1 (no stall) and no fill starts.
- FSM states: IDLE, FILL.
  - IDLE → FILL on `cpu_req` && !hit && !flush. On entry, latch the miss tag and index into `fill_addr` and clear word counter `cnt`. Clear valid[index] at the same time.
  - FILL:
    - `mem_req` = 1 and `mem_addr` = {fill tag, fill index, `cnt`, 2'b00}. The fill starts at word 0; there is no critical-word-first.
    - Each cycle with `mem_valid` high: write `mem_rdata` into data[fill index][`cnt`], then increment `cnt`.
    - When `mem_valid` arrives with `cnt` == LINE_WORDS-1: write the tag, set valid, and go to IDLE.
    - `cpu_ready` = 0 throughout FILL.
  - After FILL → IDLE, the next cycle re-evaluates and hits on the held `cpu_addr`.
- `mem_valid` is ignored while `mem_req` is low.
- Memory may return `mem_valid` in the very first FILL cycle (zero wait states).
- Flush:
  - In IDLE: clear all valid bits on the next edge. `cpu_ready` = 0 in the flush cycle.
  - In FILL: abort the fill. Clear all valid bits, go to IDLE, and drop `mem_req` next cycle. A `mem_valid` arriving in the flush cycle is discarded.
- Reset (asynchronous, any state):
  - state = IDLE, `cnt` = 0, all valid bits = 0;
  - outputs: `mem_req` = 0, `mem_addr` = 0, `cpu_ready` = 0 if `cpu_req` is high, otherwise 1;
  - the data and tag arrays are not reset.

## Timing
- Hit latency: 0 cycles (combinational).
- Miss penalty: 1 + Σ(wait states) + LINE_WORDS cycles. With a zero-wait memory, a default miss stalls 5 cycles, and the hit is returned in the 6th cycle.
- `mem_addr` advances in the cycle after each accepted `mem_valid`.
- `mem_req` stays high continuously from FILL entry until the last word is accepted.
- Addresses that differ only in offset within the filled line hit immediately after the fill.
- All state updates occur on `posedge clk`; only reset is asynchronous.

## Configuration
- `ICACHE_STATS_EN`:
  - Defined: adds two 32-bit outputs, `hit_count` and `miss_count`, both reset to 0.
    - `hit_count` increments on every IDLE cycle with `cpu_req` && hit.
    - `miss_count` increments on every IDLE → FILL transition.
    - Both counters wrap at 2^32 and are not cleared by `flush`.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg` holds:
  - FSM state enum `icache_state_t` {IDLE, FILL};
  - address-field width helper functions (offset/index/tag widths from `LINES`/`LINE_WORDS`);
  - `WORD_W` = 32.
- A single module is sufficient. Optional sub-module `icache_tag_array` holds the tag/valid storage with flush-clear and hit compare; the data array stays in the top level.

## Test plan
- Cold miss: after reset, `cpu_addr`=0x0000_0040 with zero-wait memory returning 0x1000_0000+addr.
  - Required: `cpu_ready` low for 5 cycles; `mem_addr` sequence 0x40, 0x44, 0x48, 0x4C.
  - Then `cpu_rdata`=0x1000_0040 with `cpu_ready`=1.
- Line hit: after the cold miss, step `cpu_addr` through 0x44, 0x48, 0x4C.
  - Required: `cpu_ready`=1 each cycle, data 0x1000_0044/48/4C, `mem_req` never asserted.
- Conflict eviction: fetch 0x40, then 0x140 (same index 4, different tag), then 0x40.
  - Required: three full misses, each with a 5-cycle stall, and correct data each time.
- Wait states: memory delays 3 cycles per word on a miss at 0x80.
  - Required: `mem_req` high for 16 cycles; `mem_addr` holds each word address until its `mem_valid`.
  - Total stall: 17 cycles.
- Flush mid-fill: assert `flush` during the 2nd word of the fill for 0x100.
  - Required: `mem_req` drops the next cycle and all lines become invalid.
  - A refetch of a previously cached 0x40 misses.
- Async reset mid-fill: assert `reset` between edges.
  - Required: `mem_req`=0 immediately; after release, 0x40 misses again.
  - With `ICACHE_STATS_EN` defined, both counters read 0.
